// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared types and encodings for the LEGv8 multicycle control slice
//
// Purpose: one place for the state encoding, the opcode class enum, the
//   opcode constants/masks, and the mux-select encodings. The control FSM,
//   the opcode classifier and the ALU controller all import this package.
// Ports: none (package).
package legv8_pkg;

  // Main control FSM states. The encoding is 4 bits wide.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_RWB      = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  // Opcode classes produced by legv8_opclass.
  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_B       = 3'd4,
    CLS_ILLEGAL = 3'd5
  } opclass_t;

  // Full 11-bit opcodes (IR[31:21]).
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // CBZ and B have shorter opcode fields; the low opcode bits belong to the
  // immediate, so they are matched under a mask.
  localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;
  localparam logic [10:0] OP_CBZ      = 11'b10110100000;
  localparam logic [10:0] OP_B_MASK   = 11'b11111100000;
  localparam logic [10:0] OP_B        = 11'b00010100000;

  // alu_op encodings consumed by the ALU controller.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_PASSB = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  // alu_src_b encodings.
  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_DIMM  = 2'b10;
  localparam logic [1:0] ALUSRCB_BROFF = 2'b11;

  // pc_source encodings.
  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PCSRC_BTARGET = 2'b10;

  // Masked opcode compare; a zero bit in mask makes that bit don't-care.
  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] mask,
                                    input logic [10:0] pattern);
    return (op & mask) == (pattern & mask);
  endfunction

endpackage

// File: rtl/legv8_opclass.sv
// rtl/legv8_opclass.sv - combinational LEGv8 opcode class decoder
//
// Purpose: map the 11-bit opcode IR[31:21] to an instruction class.
//   Anything that is not one of the supported encodings is CLS_ILLEGAL.
// Ports:
//   opcode  in  11  IR[31:21]
//   opclass out 3   class code (legv8_pkg::opclass_t encoding)
module legv8_opclass
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [2:0]  opclass
);

  opclass_t cls;

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode == OP_ADD || opcode == OP_SUB ||
        opcode == OP_AND || opcode == OP_ORR) begin
      cls = CLS_RTYPE;
    end else if (opcode == OP_LDUR) begin
      cls = CLS_LOAD;
    end else if (opcode == OP_STUR) begin
      cls = CLS_STORE;
    end else if (op_match(opcode, OP_CBZ_MASK, OP_CBZ)) begin
      cls = CLS_CBZ;
    end else if (op_match(opcode, OP_B_MASK, OP_B)) begin
      cls = CLS_B;
    end
  end

  assign opclass = cls;

endmodule

// File: rtl/legv8_multicycle_control.sv
// rtl/legv8_multicycle_control.sv - LEGv8 multicycle main control FSM
//
// Purpose: sequences each instruction through fetch, decode, execute,
//   memory and writeback, drives all datapath enables and mux selects,
//   counts retired instructions and halts on an illegal opcode.
// Ports:
//   clk, rst (sync, active-high)
//   opcode[10:0] IR[31:21], zero ALU zero flag (used only in BRANCH)
//   pc_write, iord, mem_read, mem_write, ir_write, reg2loc, reg_write,
//   mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]
//   illegal   sticky illegal-opcode flag
//   retired   retired-instruction count, wraps modulo 2^CNT_W
module legv8_multicycle_control
  import legv8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      opcode,
  input  logic             zero,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg2loc,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t   state;
  state_t   next_state;
  opclass_t cls;
  logic [2:0] opclass_raw;
  logic       illegal_q;
  logic [CNT_W-1:0] retired_q;

  legv8_opclass u_opclass (
    .opcode  (opcode),
    .opclass (opclass_raw)
  );

  assign cls = opclass_t'(opclass_raw);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. Everything is Moore except pc_write in
  // BRANCH, which follows zero combinationally.
  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg2loc    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUSRCB_B;
    alu_op     = ALU_OP_ADD;
    pc_source  = PCSRC_ALU;

    unique case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = ALUSRCB_FOUR;
        next_state = S_DECODE;
      end

      S_DECODE: begin
        // ALUOut captures PC + offset<<2 here so BRANCH can use it.
        alu_src_b = ALUSRCB_BROFF;
        reg2loc   = (cls == CLS_STORE) || (cls == CLS_CBZ);
        unique case (cls)
          CLS_RTYPE: next_state = S_EXEC;
          CLS_LOAD:  next_state = S_MEM_ADDR;
          CLS_STORE: next_state = S_MEM_ADDR;
          CLS_CBZ:   next_state = S_BRANCH;
          CLS_B:     next_state = S_JUMP;
          default:   next_state = S_HALT;
        endcase
      end

      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ALUSRCB_B;
        alu_op     = ALU_OP_RTYPE;
        next_state = S_RWB;
      end

      S_RWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ALUSRCB_DIMM;
        reg2loc    = (cls == CLS_STORE);
        next_state = (cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        iord       = 1'b1;
        mem_read   = 1'b1;
        next_state = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end

      S_MEM_WR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        reg2loc    = 1'b1;
        alu_op     = ALU_OP_PASSB;
        pc_source  = PCSRC_ALUOUT;
        pc_write   = zero;
        next_state = S_FETCH;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_BTARGET;
        next_state = S_FETCH;
      end

      S_HALT: begin
        next_state = S_HALT;
      end

      default: begin
        // Unused encodings recover to a clean fetch.
        next_state = S_FETCH;
      end
    endcase
  end

  // Every entry into FETCH outside reset marks a completed instruction;
  // FETCH always leaves to DECODE, so next_state alone identifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (next_state == S_FETCH) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state == S_DECODE && next_state == S_HALT) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// tb/tb_legv8_multicycle_control.sv - self-checking bench for legv8_multicycle_control
module tb_legv8_multicycle_control;

  // Expected-output vector layout:
  // {pc_write, iord, mem_read, mem_write, ir_write, reg2loc, reg_write,
  //  mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal}
  localparam logic [15:0] B_PCW  = 16'h8000;
  localparam logic [15:0] B_IORD = 16'h4000;
  localparam logic [15:0] B_MR   = 16'h2000;
  localparam logic [15:0] B_MW   = 16'h1000;
  localparam logic [15:0] B_IRW  = 16'h0800;
  localparam logic [15:0] B_R2L  = 16'h0400;
  localparam logic [15:0] B_RW   = 16'h0200;
  localparam logic [15:0] B_M2R  = 16'h0100;
  localparam logic [15:0] B_ASA  = 16'h0080;
  localparam logic [15:0] ASB_01 = 16'h0020;
  localparam logic [15:0] ASB_10 = 16'h0040;
  localparam logic [15:0] ASB_11 = 16'h0060;
  localparam logic [15:0] AOP_01 = 16'h0008;
  localparam logic [15:0] AOP_10 = 16'h0010;
  localparam logic [15:0] PCS_01 = 16'h0002;
  localparam logic [15:0] PCS_10 = 16'h0004;
  localparam logic [15:0] B_ILL  = 16'h0001;

  localparam logic [15:0] V_FETCH   = B_PCW | B_MR | B_IRW | ASB_01;
  localparam logic [15:0] V_DEC     = ASB_11;
  localparam logic [15:0] V_DEC_R2L = ASB_11 | B_R2L;
  localparam logic [15:0] V_EXEC    = B_ASA | AOP_10;
  localparam logic [15:0] V_RWB     = B_RW;
  localparam logic [15:0] V_MADDR_L = B_ASA | ASB_10;
  localparam logic [15:0] V_MADDR_S = B_ASA | ASB_10 | B_R2L;
  localparam logic [15:0] V_MRD     = B_IORD | B_MR;
  localparam logic [15:0] V_MWB     = B_RW | B_M2R;
  localparam logic [15:0] V_MWR     = B_IORD | B_MW;
  localparam logic [15:0] V_BR_T    = B_ASA | B_R2L | AOP_01 | PCS_01 | B_PCW;
  localparam logic [15:0] V_BR_NT   = B_ASA | B_R2L | AOP_01 | PCS_01;
  localparam logic [15:0] V_JUMP    = B_PCW | PCS_10;
  localparam logic [15:0] V_HALT    = B_ILL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] opcode = 11'd0;
  logic        zero = 1'b0;

  logic        pc_write, iord, mem_read, mem_write, ir_write, reg2loc;
  logic        reg_write, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [15:0] retired;

  logic        n_pc_write, n_iord, n_mem_read, n_mem_write, n_ir_write, n_reg2loc;
  logic        n_reg_write, n_mem_to_reg, n_alu_src_a, n_illegal;
  logic [1:0]  n_alu_src_b, n_alu_op, n_pc_source;
  logic [3:0]  n_retired;

  always #5 clk = ~clk;

  legv8_multicycle_control #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg2loc(reg2loc), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal(illegal), .retired(retired)
  );

  // Narrow-counter instance for the wrap check; driven identically.
  legv8_multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_write(n_pc_write), .iord(n_iord), .mem_read(n_mem_read), .mem_write(n_mem_write),
    .ir_write(n_ir_write), .reg2loc(n_reg2loc), .reg_write(n_reg_write),
    .mem_to_reg(n_mem_to_reg), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
    .alu_op(n_alu_op), .pc_source(n_pc_source), .illegal(n_illegal), .retired(n_retired)
  );

  wire [15:0] act_vec = {pc_write, iord, mem_read, mem_write, ir_write, reg2loc,
                         reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                         pc_source, illegal};

  typedef struct {
    string       name;
    logic [10:0] op;
    logic        z;
    int          n;
    logic [4:0][15:0] exp;
  } rec_t;

  typedef struct {
    string       tag;
    logic [15:0] vec;
  } sb_t;

  rec_t recs [11];
  sb_t  sb [$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ret = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: queue the expectation, sample at the falling edge, pop and compare.
  task automatic run_cycle(input string tag, input logic [15:0] expv);
    sb_t it;
    sb.push_back('{tag, expv});
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      it = sb.pop_front();
      check({it.tag, " outputs"}, act_vec, it.vec);
      check({it.tag, " retired"}, retired, 16'(exp_ret));
      check({it.tag, " retired4"}, {12'd0, n_retired}, {12'd0, 4'(exp_ret)});
    end
  endtask

  task automatic run_rec(input int i);
    opcode = recs[i].op;
    zero   = recs[i].z;
    for (int c = 0; c < recs[i].n; c++) begin
      run_cycle($sformatf("%s c%0d", recs[i].name, c), recs[i].exp[c]);
    end
    exp_ret++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    exp_ret = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    recs[0]  = '{"ADD",  11'b10001011000, 1'b0, 4, {16'h0, V_RWB, V_EXEC, V_DEC, V_FETCH}};
    recs[1]  = '{"SUB",  11'b11001011000, 1'b0, 4, {16'h0, V_RWB, V_EXEC, V_DEC, V_FETCH}};
    recs[2]  = '{"AND",  11'b10001010000, 1'b0, 4, {16'h0, V_RWB, V_EXEC, V_DEC, V_FETCH}};
    recs[3]  = '{"ORR",  11'b10101010000, 1'b0, 4, {16'h0, V_RWB, V_EXEC, V_DEC, V_FETCH}};
    recs[4]  = '{"LDUR", 11'b11111000010, 1'b0, 5, {V_MWB, V_MRD, V_MADDR_L, V_DEC, V_FETCH}};
    recs[5]  = '{"STUR", 11'b11111000000, 1'b0, 4, {16'h0, V_MWR, V_MADDR_S, V_DEC_R2L, V_FETCH}};
    recs[6]  = '{"CBZ_T", 11'b10110100101, 1'b1, 3, {16'h0, 16'h0, V_BR_T, V_DEC_R2L, V_FETCH}};
    recs[7]  = '{"CBZ_NT", 11'b10110100101, 1'b0, 3, {16'h0, 16'h0, V_BR_NT, V_DEC_R2L, V_FETCH}};
    recs[8]  = '{"CBZ_T2", 11'b10110100010, 1'b1, 3, {16'h0, 16'h0, V_BR_T, V_DEC_R2L, V_FETCH}};
    recs[9]  = '{"B",    11'b00010100000, 1'b0, 3, {16'h0, 16'h0, V_JUMP, V_DEC, V_FETCH}};
    recs[10] = '{"B2",   11'b00010111111, 1'b1, 3, {16'h0, 16'h0, V_JUMP, V_DEC, V_FETCH}};

    do_reset(3);

    // Every legal class, back to back.
    for (int i = 0; i < 11; i++) run_rec(i);

    // Illegal opcode: HALT after DECODE, flag set, nothing moves for 10 cycles.
    opcode = 11'b00000000000;
    run_cycle("ILL fetch", V_FETCH);
    run_cycle("ILL decode", V_DEC);
    for (int c = 0; c < 10; c++) run_cycle($sformatf("HALT c%0d", c), V_HALT);

    // Reset out of HALT clears the flag and the counter.
    do_reset(1);
    run_rec(0);

    // Near-miss of ADD (bit 0 set) is illegal too.
    opcode = 11'b10001011001;
    run_cycle("ILL2 fetch", V_FETCH);
    run_cycle("ILL2 decode", V_DEC);
    for (int c = 0; c < 3; c++) run_cycle($sformatf("HALT2 c%0d", c), V_HALT);
    do_reset(1);

    // Reset during MEM_RD abandons the load without counting it.
    run_rec(1);
    opcode = 11'b11111000010;
    run_cycle("LD_ABORT fetch", V_FETCH);
    run_cycle("LD_ABORT decode", V_DEC);
    run_cycle("LD_ABORT maddr", V_MADDR_L);
    run_cycle("LD_ABORT mrd", V_MRD);
    do_reset(1);
    run_cycle("POST_ABORT fetch", V_FETCH);
    run_cycle("POST_ABORT decode", V_DEC);
    do_reset(1);

    // 17 instructions: the 4-bit counter wraps to 0 at 16 and reaches 1.
    for (int k = 0; k < 17; k++) run_rec(k % 11);
    run_cycle("FINAL fetch", V_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
